// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and register map for the memory-mapped UART transmitter
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  localparam int OFS_DATA = 0;
  localparam int OFS_STAT = 1;

  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with wrap-bit pointers and a combinational head output
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wrPtr;
  logic [AW:0]      rdPtr;
  logic             doPush;
  logic             doPop;

  assign count  = wrPtr - rdPtr;
  assign full   = (count == (AW+1)'(DEPTH));
  assign empty  = (wrPtr == rdPtr);
  assign doPush = push && !full;
  assign doPop  = pop && !empty;
  assign dout   = mem[rdPtr[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
    end
  end

  // Storage needs no reset: the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - CPU-store-fed 8N1 serial transmitter with status register
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR    = 8'hF0,
  parameter int         FIFO_DEPTH   = 4,
  parameter int         CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       WE,
  input  logic [7:0] DataAddr,
  input  logic [7:0] WriteData,
  output logic       Sel,
  output logic [7:0] RdData,
  output logic       tx,
  output logic       busy
);

  localparam int              BW        = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0]   BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  tx_state_t                    state;
  logic [BW-1:0]                baudCnt;
  logic [2:0]                   bitIdx;
  logic [7:0]                   shiftReg;
  logic                         overflow;
  logic                         lineTail;
  logic                         baudLast;
  logic                         hitData;
  logic                         hitStat;
  logic                         pushReq;
  logic                         dropPush;
  logic                         clrOvf;
  logic                         fifoPop;
  logic                         fifoFull;
  logic                         fifoEmpty;
  logic [7:0]                   fifoHead;
  logic [$clog2(FIFO_DEPTH):0]  fifoCount;
  logic                         txNext;
  logic [7:0]                   statusByte;

  assign hitData  = (DataAddr == BASE_ADDR + 8'(OFS_DATA));
  assign hitStat  = (DataAddr == BASE_ADDR + 8'(OFS_STAT));
  assign Sel      = hitData || hitStat;
  assign pushReq  = WE && hitData;
  assign dropPush = pushReq && fifoFull;
  assign clrOvf   = WE && hitStat;
  assign fifoPop  = (state == IDLE) && !fifoEmpty;
  assign baudLast = (baudCnt == BAUD_LAST);

  // tx lags the FSM by one cycle, so busy also covers the last stop-bit cycle still on the line.
  assign busy = (state != IDLE) || (fifoCount != '0) || lineTail;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (pushReq),
    .pop   (fifoPop),
    .din   (WriteData),
    .dout  (fifoHead),
    .full  (fifoFull),
    .empty (fifoEmpty),
    .count (fifoCount)
  );

  always_comb begin
    statusByte           = 8'h00;
    statusByte[ST_FULL]  = fifoFull;
    statusByte[ST_EMPTY] = fifoEmpty;
    statusByte[ST_BUSY]  = busy;
    statusByte[ST_OVF]   = overflow;
  end

  assign RdData = Sel ? statusByte : 8'h00;

  always_comb begin
    txNext = 1'b1;
    case (state)
      START:   txNext = 1'b0;
      DATA:    txNext = shiftReg[0];
      default: txNext = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      baudCnt  <= '0;
      bitIdx   <= '0;
      shiftReg <= '0;
      tx       <= 1'b1;
      lineTail <= 1'b0;
      overflow <= 1'b0;
    end else begin
      tx       <= txNext;
      lineTail <= (state == STOP) && baudLast;

      // A dropped push outranks a clear landing on the same edge.
      if (dropPush)    overflow <= 1'b1;
      else if (clrOvf) overflow <= 1'b0;

      case (state)
        IDLE: begin
          baudCnt <= '0;
          if (fifoPop) begin
            shiftReg <= fifoHead;
            state    <= START;
          end
        end
        START: begin
          if (baudLast) begin
            baudCnt <= '0;
            bitIdx  <= '0;
            state   <= DATA;
          end else begin
            baudCnt <= baudCnt + 1'b1;
          end
        end
        DATA: begin
          if (baudLast) begin
            baudCnt  <= '0;
            shiftReg <= {1'b0, shiftReg[7:1]};
            bitIdx   <= bitIdx + 3'd1;
            if (bitIdx == 3'd7) state <= STOP;
          end else begin
            baudCnt <= baudCnt + 1'b1;
          end
        end
        STOP: begin
          if (baudLast) begin
            baudCnt <= '0;
            state   <= IDLE;
          end else begin
            baudCnt <= baudCnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - directed self-checking bench for mmio_uart_tx
`timescale 1us/1ns
module tb_mmio_uart_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       WE = 1'b0;
  logic [7:0] DataAddr = 8'hF1;
  logic [7:0] WriteData = 8'h00;
  logic       Sel;
  logic [7:0] RdData;
  logic       tx;
  logic       busy;

  int nCmp = 0;
  int nErr = 0;

  always #500 clk = ~clk;

  mmio_uart_tx #(.BASE_ADDR(8'hF0), .FIFO_DEPTH(4), .CLKS_PER_BIT(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .WE        (WE),
    .DataAddr  (DataAddr),
    .WriteData (WriteData),
    .Sel       (Sel),
    .RdData    (RdData),
    .tx        (tx),
    .busy      (busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  // Expected line level at position pos (0 = first start-bit cycle) of a 4-clock-per-bit frame.
  function automatic logic frameTx(input logic [7:0] b, input int pos);
    if (pos < 4)  return 1'b0;
    if (pos < 36) return b[(pos - 4) / 4];
    return 1'b1;
  endfunction

  // Five back-to-back frames of bytes 1..5, 41 cycles apart, first start bit 2 cycles after the first push.
  function automatic logic streamTx(input int k);
    int f;
    if (k < 2) return 1'b1;
    f = (k - 2) / 41;
    if (f >= 5) return 1'b1;
    return frameTx(8'(f + 1), (k - 2) % 41);
  endfunction

  initial begin
    // Scenario 1: reset state
    step();
    step();
    #1;
    chk("rst_tx", {7'd0, tx}, 8'h01);
    chk("rst_busy", {7'd0, busy}, 8'h00);
    reset = 1'b1;
    step();
    chk("idle_tx", {7'd0, tx}, 8'h01);
    chk("idle_busy", {7'd0, busy}, 8'h00);
    chk("idle_sel", {7'd0, Sel}, 8'h01);
    chk("idle_stat", RdData, 8'h02);
    DataAddr = 8'hF0;
    #1;
    chk("sel_data", {7'd0, Sel}, 8'h01);
    step();

    // Scenario 2: single frame of 8'hA5
    WE = 1'b1; DataAddr = 8'hF0; WriteData = 8'hA5;
    step();
    WE = 1'b0; DataAddr = 8'hF1;
    for (int k = 0; k < 46; k++) begin
      chk($sformatf("a5_tx_%0d", k), {7'd0, tx}, {7'd0, (k < 2) ? 1'b1 : (k < 42) ? frameTx(8'hA5, k - 2) : 1'b1});
      chk($sformatf("a5_busy_%0d", k), {7'd0, busy}, {7'd0, (k <= 41)});
      step();
    end
    chk("a5_stat_after", RdData, 8'h02);

    // Scenario 3: six stores, the sixth overflows
    WE = 1'b1; DataAddr = 8'hF0; WriteData = 8'h01;
    step();
    for (int k = 0; k < 213; k++) begin
      if (k < 5) WriteData = 8'(k + 2);
      if (k == 5) begin
        WE = 1'b0;
        DataAddr = 8'hF1;
        #1;
        chk("ovf_stat_full", RdData, 8'h0D);
      end
      chk($sformatf("burst_tx_%0d", k), {7'd0, tx}, {7'd0, streamTx(k)});
      if (k == 205) chk("burst_busy_tail", {7'd0, busy}, 8'h01);
      if (k == 210) chk("burst_busy_end", {7'd0, busy}, 8'h00);
      step();
    end
    chk("ovf_sticky", RdData, 8'h0A);

    // Scenario 4: clear overflow with a status write
    WE = 1'b1; DataAddr = 8'hF1; WriteData = 8'h5A;
    step();
    WE = 1'b0;
    #1;
    chk("ovf_clear", RdData, 8'h02);
    step();

    // Scenario 5: reset mid-frame with two bytes queued
    WE = 1'b1; DataAddr = 8'hF0; WriteData = 8'h11;
    step();
    WriteData = 8'h22;
    step();
    WriteData = 8'h33;
    step();
    WE = 1'b0; DataAddr = 8'hF1;
    for (int k = 3; k <= 17; k++) step();
    chk("mid_frame_tx", {7'd0, tx}, 8'h00);
    chk("mid_frame_stat", RdData, 8'h04);
    reset = 1'b0;
    #1;
    chk("abort_tx", {7'd0, tx}, 8'h01);
    chk("abort_stat", RdData, 8'h02);
    chk("abort_busy", {7'd0, busy}, 8'h00);
    step();
    step();
    reset = 1'b1;
    for (int k = 0; k < 60; k++) begin
      step();
      chk($sformatf("post_rst_tx_%0d", k), {7'd0, tx}, 8'h01);
      chk($sformatf("post_rst_busy_%0d", k), {7'd0, busy}, 8'h00);
    end

    // Scenario 6: writes outside the window are ignored
    WE = 1'b1; DataAddr = 8'hEF; WriteData = 8'hFF;
    #1;
    chk("oob_lo_sel", {7'd0, Sel}, 8'h00);
    chk("oob_lo_rd", RdData, 8'h00);
    step();
    DataAddr = 8'hF2;
    #1;
    chk("oob_hi_sel", {7'd0, Sel}, 8'h00);
    chk("oob_hi_rd", RdData, 8'h00);
    step();
    WE = 1'b0; DataAddr = 8'hF1;
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("oob_tx_%0d", k), {7'd0, tx}, 8'h01);
      step();
    end
    chk("oob_stat", RdData, 8'h02);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
